// File: rtl/display_set_controller.sv
// Front-panel time-set sequencer: owns the display mode, walks the edit fields
// left->mid->right, and emits a one-cycle commit of the edit buffer.
module display_set_controller #(
  parameter int MAX_LEFT  = 23,
  parameter int MAX_MID   = 59,
  parameter int MAX_RIGHT = 59,
  parameter int TIMEOUT_S = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_set,
  input  logic        btn_up,
  input  logic        tick_1hz,
  input  logic [20:0] cur_clock,
  input  logic [20:0] cur_alarm,
  output logic [1:0]  display_mode,
  output logic [2:0]  flash,
  output logic        editing,
  output logic [20:0] edit_time,
  output logic        load_en,
  output logic        load_alarm
);

  localparam int CW = ($clog2(TIMEOUT_S + 1) > 4) ? $clog2(TIMEOUT_S + 1) : 4;

  typedef enum logic [1:0] {RUN, SET_L, SET_M, SET_R} state_t;

  state_t         state_q, state_d;
  logic [1:0]     mode_q, mode_d;
  logic [2:0]     flash_q, flash_d;
  logic           editing_q, editing_d;
  logic [20:0]    edit_q, edit_d;
  logic           load_en_q, load_en_d;
  logic           load_alarm_q, load_alarm_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Values already past the field maximum (e.g. 99 from an uninitialised
  // register) fold straight back to 0 on the first increment.
  function automatic logic [6:0] bump(input logic [6:0] v, input logic [6:0] max_v);
    return (v >= max_v) ? 7'd0 : v + 7'd1;
  endfunction

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    flash_d      = flash_q;
    editing_d    = editing_q;
    edit_d       = edit_q;
    load_en_d    = 1'b0;
    load_alarm_d = load_alarm_q;
    cnt_d        = cnt_q;

    case (state_q)
      RUN: begin
        if (btn_set) begin
          if (mode_q != 2'd1) begin
            edit_d       = (mode_q == 2'd2) ? cur_alarm : cur_clock;
            load_alarm_d = (mode_q == 2'd2);
            state_d      = SET_L;
            flash_d      = 3'b100;
            editing_d    = 1'b1;
            cnt_d        = '0;
          end
        end else if (btn_up) begin
          // btn_up outranks btn_mode but does nothing while running
        end else if (btn_mode) begin
          mode_d = (mode_q >= 2'd2) ? 2'd0 : mode_q + 2'd1;
        end
      end

      default: begin
        if (btn_set) begin
          cnt_d = '0;
          case (state_q)
            SET_L: begin state_d = SET_M; flash_d = 3'b010; end
            SET_M: begin state_d = SET_R; flash_d = 3'b001; end
            default: begin
              state_d   = RUN;
              flash_d   = 3'b000;
              editing_d = 1'b0;
              load_en_d = 1'b1;
            end
          endcase
        end else if (btn_up) begin
          cnt_d = '0;
          case (state_q)
            SET_L:   edit_d[20:14] = bump(edit_q[20:14], 7'(MAX_LEFT));
            SET_M:   edit_d[13:7]  = bump(edit_q[13:7],  7'(MAX_MID));
            default: edit_d[6:0]   = bump(edit_q[6:0],   7'(MAX_RIGHT));
          endcase
        end else if (tick_1hz) begin
          if (cnt_q >= CW'(TIMEOUT_S - 1)) begin
            cnt_d     = CW'(TIMEOUT_S);
            state_d   = RUN;
            flash_d   = 3'b000;
            editing_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      mode_q       <= 2'd0;
      flash_q      <= 3'b000;
      editing_q    <= 1'b0;
      edit_q       <= '0;
      load_en_q    <= 1'b0;
      load_alarm_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      flash_q      <= flash_d;
      editing_q    <= editing_d;
      edit_q       <= edit_d;
      load_en_q    <= load_en_d;
      load_alarm_q <= load_alarm_d;
      cnt_q        <= cnt_d;
    end
  end

  assign display_mode = mode_q;
  assign flash        = flash_q;
  assign editing      = editing_q;
  assign edit_time    = edit_q;
  assign load_en      = load_en_q;
  assign load_alarm   = load_alarm_q;

endmodule
